// File: rtl/rgb_fade_pwm_if.sv
// Colour-code input and LED pin bundle between the colour sequencer and rgb_fade_pwm.
interface rgb_fade_pwm_if;
  logic       en;
  logic [2:0] colour;
  logic       led_r;
  logic       led_g;
  logic       led_b;
  logic       busy;

  modport master (
    output en,
    output colour,
    input  led_r,
    input  led_g,
    input  led_b,
    input  busy
  );

  modport slave (
    input  en,
    input  colour,
    output led_r,
    output led_g,
    output led_b,
    output busy
  );
endinterface

// File: rtl/rgb_fade_pwm.sv
// Three-channel LED PWM driver with linear cross-fade between colour codes.
// Define RGB_FADE_EN to build the fade engine; otherwise levels follow the colour directly.
module rgb_fade_pwm #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned FADE_DIV = 1024,
  parameter int unsigned STEP     = 8
) (
  input  logic          clk,
  input  logic          rst,
  rgb_fade_pwm_if.slave bus
);

  localparam int unsigned      MAX    = (32'd1 << CNT_W) - 32'd1;
  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX);
  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(MAX - 32'd1);

  // Reject configurations the saturating step arithmetic cannot handle.
  if (FADE_DIV == 0 || STEP == 0 || STEP > MAX) begin : g_bad_cfg
    $error("rgb_fade_pwm: FADE_DIV must be >= 1 and STEP within 1..MAX");
  end

  logic [2:0]            colour_q, colour_d;
  logic [2:0][CNT_W-1:0] level_q, level_d;
  logic [2:0][CNT_W-1:0] duty_q, duty_d;
  logic [2:0][CNT_W-1:0] target_c;
  logic [CNT_W-1:0]      pwm_cnt_q, pwm_cnt_d;
  logic [2:0]            led_q, led_d;
  logic                  busy_q, busy_d;
  logic                  wrap_c;

`ifdef RGB_FADE_EN
  localparam int unsigned      PRE_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [CNT_W-1:0] STEP_V = CNT_W'(STEP);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic             tick_c;

  // One fade step toward the target, landing exactly on it when within STEP.
  function automatic logic [CNT_W-1:0] step_toward(input logic [CNT_W-1:0] lvl,
                                                   input logic [CNT_W-1:0] tgt);
    logic [CNT_W-1:0] res;
    res = lvl;
    if (lvl < tgt) begin
      res = ((tgt - lvl) <= STEP_V) ? tgt : lvl + STEP_V;
    end else if (lvl > tgt) begin
      res = ((lvl - tgt) <= STEP_V) ? tgt : lvl - STEP_V;
    end
    return res;
  endfunction
`endif

  // Next-state: colour sampling, PWM counter, duty reload at wrap, fade.
  always_comb begin
    colour_d  = bus.colour;
    level_d   = level_q;
    duty_d    = duty_q;
    pwm_cnt_d = pwm_cnt_q;
    led_d     = '0;
    busy_d    = 1'b0;
    wrap_c    = (pwm_cnt_q == LAST_V);
    for (int c = 0; c < 3; c++) begin
      target_c[c] = colour_q[c] ? MAX_V : '0;
    end
`ifdef RGB_FADE_EN
    presc_d = presc_q;
    tick_c  = 1'b0;
`endif

    if (bus.en) begin
      pwm_cnt_d = wrap_c ? '0 : pwm_cnt_q + CNT_W'(1);
      if (wrap_c) begin
        duty_d = level_q;
      end
      for (int c = 0; c < 3; c++) begin
        led_d[c] = (pwm_cnt_q < duty_q[c]);
      end
`ifdef RGB_FADE_EN
      tick_c  = (presc_q == PRE_W'(FADE_DIV - 1));
      presc_d = tick_c ? '0 : presc_q + PRE_W'(1);
`else
      level_d = target_c;
`endif
    end

`ifdef RGB_FADE_EN
    // Levels and busy are judged against the registered colour, independent of en.
    for (int c = 0; c < 3; c++) begin
      if (tick_c) begin
        level_d[c] = step_toward(level_q[c], target_c[c]);
      end
      busy_d = busy_d | (level_q[c] != target_c[c]);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colour_q  <= '0;
      level_q   <= '0;
      duty_q    <= '0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
      busy_q    <= 1'b0;
`ifdef RGB_FADE_EN
      presc_q   <= '0;
`endif
    end else begin
      colour_q  <= colour_d;
      level_q   <= level_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
`ifdef RGB_FADE_EN
      presc_q   <= presc_d;
`endif
    end
  end

  assign bus.led_r = led_q[0];
  assign bus.led_g = led_q[1];
  assign bus.led_b = led_q[2];
  assign bus.busy  = busy_q;

endmodule
